// File: rtl/rv_imm_enc_pkg.sv
// Shared constants and enum types for the rv_imm_enc constant-materialisation encoder.
package rv_imm_enc_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_LUI = 2'd1,
        EMIT_ADD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SMALL = 2'd0,
        MID   = 2'd1,
        OOR   = 2'd2
    } class_e;

    typedef enum logic {
        KIND_LUI = 1'b0,
        KIND_ADD = 1'b1
    } kind_e;

endpackage

// File: rtl/rv_imm_enc_fmt.sv
// Combinational formatter: builds a LUI or ADDI/ADDIW word from its fields.
module rv_imm_enc_fmt
    import rv_imm_enc_pkg::*;
(
    input  kind_e       kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [19:0] hi20_i,
    input  logic [11:0] lo12_i,
    input  logic        is_w_i,
    output logic [31:0] instr_o
);

    always_comb begin
        if (kind_i == KIND_LUI) begin
            instr_o = {hi20_i, rd_i, OPC_LUI};
        end else begin
            instr_o = {lo12_i, rs1_i, FUNCT3_ADDI, rd_i, (is_w_i ? OPC_OPIMM32 : OPC_OPIMM)};
        end
    end

endmodule

// File: rtl/rv_imm_enc.sv
// Turns a signed constant into the LUI/ADDI(W) words that rebuild it, one word per handshake.
// Optional build macro RV_IMM_ENC_ZERO_LO_SKIP_EN drops the trailing ADD when lo12 is zero.
module rv_imm_enc
    import rv_imm_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  val_valid_i,
    output logic                  val_ready_o,
    input  logic [DATA_WIDTH-1:0] val_i,
    input  logic [4:0]            rd_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic                  instr_last_o,
    output logic                  range_err_o
);

    localparam logic IS_W = (DATA_WIDTH == 64);

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] lo12_q, lo12_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        instr_last_q, instr_last_d;
    logic        range_err_q, range_err_d;

    logic [DATA_WIDTH-12:0] top_small;
    logic [DATA_WIDTH-32:0] top_mid;
    class_e                 cls;
    logic [19:0]            hi20_in;
    logic                   skip_add;

    kind_e       fmt_kind;
    logic [4:0]  fmt_rd, fmt_rs1;
    logic [19:0] fmt_hi20;
    logic [11:0] fmt_lo12;
    logic        fmt_is_w;
    logic [31:0] fmt_word;

    // Adding 0x800 before taking bits [31:12] is the same as adding bit 11 at bit 12.
    assign hi20_in   = val_i[31:12] + {19'd0, val_i[11]};
    assign top_small = val_i[DATA_WIDTH-1:11];
    assign top_mid   = val_i[DATA_WIDTH-1:31];

    always_comb begin
        if ((&top_small) || (~|top_small)) begin
            cls = SMALL;
        end else if ((&top_mid) || (~|top_mid)) begin
            cls = MID;
        end else begin
            cls = OOR;
        end
    end

`ifdef RV_IMM_ENC_ZERO_LO_SKIP_EN
    assign skip_add = (val_i[11:0] == 12'd0);
`else
    assign skip_add = 1'b0;
`endif

    // In IDLE the formatter sees the fresh request; afterwards only the ADD word remains.
    always_comb begin
        if (state_q == IDLE) begin
            fmt_kind = (cls == SMALL) ? KIND_ADD : KIND_LUI;
            fmt_rd   = rd_i;
            fmt_rs1  = 5'd0;
            fmt_hi20 = hi20_in;
            fmt_lo12 = val_i[11:0];
            fmt_is_w = 1'b0;
        end else begin
            fmt_kind = KIND_ADD;
            fmt_rd   = rd_q;
            fmt_rs1  = rd_q;
            fmt_hi20 = 20'd0;
            fmt_lo12 = lo12_q;
            fmt_is_w = IS_W;
        end
    end

    rv_imm_enc_fmt u_fmt (
        .kind_i  (fmt_kind),
        .rd_i    (fmt_rd),
        .rs1_i   (fmt_rs1),
        .hi20_i  (fmt_hi20),
        .lo12_i  (fmt_lo12),
        .is_w_i  (fmt_is_w),
        .instr_o (fmt_word)
    );

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        lo12_d        = lo12_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_last_d  = instr_last_q;
        range_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (val_valid_i) begin
                    rd_d   = rd_i;
                    lo12_d = val_i[11:0];
                    case (cls)
                        SMALL: begin
                            instr_d       = fmt_word;
                            instr_valid_d = 1'b1;
                            instr_last_d  = 1'b1;
                            state_d       = EMIT_ADD;
                        end
                        MID: begin
                            instr_d       = fmt_word;
                            instr_valid_d = 1'b1;
                            instr_last_d  = skip_add;
                            state_d       = EMIT_LUI;
                        end
                        default: begin
                            range_err_d = 1'b1;
                        end
                    endcase
                end
            end
            EMIT_LUI: begin
                if (instr_ready_i) begin
                    if (instr_last_q) begin
                        instr_valid_d = 1'b0;
                        instr_last_d  = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        instr_d      = fmt_word;
                        instr_last_d = 1'b1;
                        state_d      = EMIT_ADD;
                    end
                end
            end
            EMIT_ADD: begin
                if (instr_ready_i) begin
                    instr_valid_d = 1'b0;
                    instr_last_d  = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            rd_q          <= 5'd0;
            lo12_q        <= 12'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_last_q  <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            lo12_q        <= lo12_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_last_q  <= instr_last_d;
            range_err_q   <= range_err_d;
        end
    end

    assign val_ready_o   = (state_q == IDLE);
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_last_o  = instr_last_q;
    assign range_err_o   = range_err_q;

endmodule

// File: tb/tb_rv_imm_enc.sv
// Directed table-driven bench for rv_imm_enc (DATA_WIDTH=64), plus stall and reset sequences.
module tb_rv_imm_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        val_valid;
    logic        val_ready_o;
    logic [63:0] val;
    logic [4:0]  rd;
    logic        instr_valid_o;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic        instr_last_o;
    logic        range_err_o;

    always #5 clk = ~clk;

    rv_imm_enc #(.DATA_WIDTH(64)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .val_valid_i   (val_valid),
        .val_ready_o   (val_ready_o),
        .val_i         (val),
        .rd_i          (rd),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready),
        .instr_o       (instr_o),
        .instr_last_o  (instr_last_o),
        .range_err_o   (range_err_o)
    );

    typedef struct {
        logic [63:0] val;
        logic [4:0]  rd;
        int          n;
        logic [31:0] w0;
        logic        l0;
        logic [31:0] w1;
        logic        l1;
        int          err;
        int          rdy_at;
    } vec_t;

    vec_t        vecs[10];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] got_w[4];
    logic        got_l[4];
    int          n_got;
    int          err_cnt;
    int          rdy_at;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one request, optionally stall the first word, then drain with ready held high.
    task automatic do_req(input logic [63:0] v, input logic [4:0] r, input int stall);
        int          guard;
        logic [31:0] hold_w;
        logic        hold_l;
        n_got   = 0;
        err_cnt = 0;
        rdy_at  = -1;
        guard   = 0;
        @(negedge clk);
        val_valid   = 1'b1;
        val         = v;
        rd          = r;
        instr_ready = 1'b0;
        while (!val_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", 64'(guard < 20), 64'd1);
        @(negedge clk);
        val_valid = 1'b0;
        hold_w    = instr_o;
        hold_l    = instr_last_o;
        for (int s = 0; s < stall; s++) begin
            err_cnt += int'(range_err_o);
            @(negedge clk);
            chk("stall_valid", 64'(instr_valid_o), 64'd1);
            chk("stall_word", 64'(instr_o), 64'(hold_w));
            chk("stall_last", 64'(instr_last_o), 64'(hold_l));
        end
        instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            err_cnt += int'(range_err_o);
            if (val_ready_o && rdy_at < 0) rdy_at = j;
            if (instr_valid_o && n_got < 4) begin
                got_w[n_got] = instr_o;
                got_l[n_got] = instr_last_o;
                n_got++;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
    endtask

    task automatic check_result(input vec_t e, input int idx);
        chk($sformatf("v%0d_nwords", idx), 64'(n_got), 64'(e.n));
        if (e.n >= 1 && n_got >= 1) begin
            chk($sformatf("v%0d_w0", idx), 64'(got_w[0]), 64'(e.w0));
            chk($sformatf("v%0d_l0", idx), 64'(got_l[0]), 64'(e.l0));
        end
        if (e.n >= 2 && n_got >= 2) begin
            chk($sformatf("v%0d_w1", idx), 64'(got_w[1]), 64'(e.w1));
            chk($sformatf("v%0d_l1", idx), 64'(got_l[1]), 64'(e.l1));
        end
        chk($sformatf("v%0d_range_err", idx), 64'(err_cnt), 64'(e.err));
        chk($sformatf("v%0d_ready_at", idx), 64'(rdy_at), 64'(e.rdy_at));
    endtask

    initial begin
        int   cnt;
        vec_t stall_exp;

        vecs[0] = '{64'h5, 5'd1, 1, 32'h00500093, 1'b1, 32'h0, 1'b0, 0, 1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1, 32'hFFF00113, 1'b1, 32'h0, 1'b0, 0, 1};
        vecs[2] = '{64'h7FFF_F800, 5'd5, 2, 32'h800002B7, 1'b0, 32'h8002829B, 1'b1, 0, 2};
        vecs[3] = '{64'h1_0000_0000, 5'd7, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 0};
        vecs[4] = '{64'h7FF, 5'd0, 1, 32'h7FF00013, 1'b1, 32'h0, 1'b0, 0, 1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_F800, 5'd10, 1, 32'h80000513, 1'b1, 32'h0, 1'b0, 0, 1};
        vecs[6] = '{64'h800, 5'd4, 2, 32'h00001237, 1'b0, 32'h8002021B, 1'b1, 0, 2};
`ifdef RV_IMM_ENC_ZERO_LO_SKIP_EN
        vecs[7] = '{64'hFFFF_FFFF_8000_0000, 5'd6, 1, 32'h80000337, 1'b1, 32'h0, 1'b0, 0, 1};
        stall_exp = '{64'h1234_5000, 5'd3, 1, 32'h123451B7, 1'b1, 32'h0, 1'b0, 0, 1};
`else
        vecs[7] = '{64'hFFFF_FFFF_8000_0000, 5'd6, 2, 32'h80000337, 1'b0, 32'h0003031B, 1'b1, 0, 2};
        stall_exp = '{64'h1234_5000, 5'd3, 2, 32'h123451B7, 1'b0, 32'h0001819B, 1'b1, 0, 2};
`endif
        vecs[8] = '{64'h8000_0000, 5'd1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 0};
        vecs[9] = '{64'hFFFF_FFFF_7FFF_FFFF, 5'd9, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 0};

        rst_n       = 1'b0;
        val_valid   = 1'b0;
        val         = 64'd0;
        rd          = 5'd0;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_val_ready", 64'(val_ready_o), 64'd1);
        chk("reset_instr_valid", 64'(instr_valid_o), 64'd0);
        chk("reset_instr", 64'(instr_o), 64'd0);
        chk("reset_last", 64'(instr_last_o), 64'd0);
        chk("reset_range_err", 64'(range_err_o), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].val, vecs[i].rd, 0);
            check_result(vecs[i], i);
        end

        do_req(stall_exp.val, stall_exp.rd, 4);
        check_result(stall_exp, 10);

        // Reset while the LUI word is pending: no ADD word may follow.
        @(negedge clk);
        val_valid   = 1'b1;
        val         = 64'h7FFF_F800;
        rd          = 5'd5;
        instr_ready = 1'b0;
        @(negedge clk);
        val_valid = 1'b0;
        chk("rst_pre_valid", 64'(instr_valid_o), 64'd1);
        chk("rst_pre_word", 64'(instr_o), 64'h800002B7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(instr_valid_o), 64'd0);
        chk("rst_async_instr", 64'(instr_o), 64'd0);
        chk("rst_async_last", 64'(instr_last_o), 64'd0);
        chk("rst_async_ready", 64'(val_ready_o), 64'd1);
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        cnt         = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            cnt += int'(instr_valid_o);
        end
        chk("rst_no_partial_word", 64'(cnt), 64'd0);
        chk("rst_idle_ready", 64'(val_ready_o), 64'd1);

        do_req(vecs[0].val, vecs[0].rd, 0);
        check_result(vecs[0], 11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
